stopwatch_core: RTL and testbench

Timing and control stage of the Nexys3 stopwatch demo. It debounces the start/stop and clear buttons, divides the system clock down to a 1 ms tick, and runs a 4-digit BCD seconds counter with the format X.XXX (0.000–9.999 s). Its cntr and dispen outputs feed the 7-segment scan controller directly; that controller lights the decimal point on the leftmost digit.

---
 rtl/stopwatch_core.sv | 182 ++++++++++++++++++
 tb/tb_stopwatch_core.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// stopwatch_core: button conditioning, 1 ms prescaler and 4-digit BCD stopwatch FSM.
// Define STOPWATCH_OVF_BLINK_EN to blink dispen while saturated in OVF.
module stopwatch_core #(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_ss,
  input  logic        btn_clr,
  output logic [15:0] cntr,
  output logic        dispen,
  output logic        running,
  output logic        ovf
);

  localparam int unsigned PW  = $clog2(TICK_DIV);
  localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DBW-1:0] DB_MAX    = DBW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_OVF} state_t;

  if (TICK_DIV < 2 || DB_CYCLES < 1 || BLINK_TICKS < 1) begin : g_param_chk
    $error("stopwatch_core: TICK_DIV >= 2, DB_CYCLES >= 1, BLINK_TICKS >= 1 required");
  end

  // Bit 0 is start/stop, bit 1 is clear.
  logic [1:0]          btn_raw;
  logic [1:0]          sync1_q, sync2_q, lvl_q, lvl_dly_q, ev_q;
  logic [1:0][DBW-1:0] db_cnt_q;
  logic                ss_ev, clr_ev;

  assign btn_raw = {btn_clr, btn_ss};
  assign ss_ev   = ev_q[0];
  assign clr_ev  = ev_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      ev_q      <= '0;
      db_cnt_q  <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      lvl_dly_q <= lvl_q;
      ev_q      <= lvl_q & ~lvl_dly_q;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2_q[i] == lvl_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_MAX) begin
          db_cnt_q[i] <= '0;
          lvl_q[i]    <= ~lvl_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned d = 0; d < 4; d++) begin
      if (carry) begin
        if (v[d*4 +: 4] >= 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [15:0]   cntr_q, cntr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, ovf_q;
  logic          presc_en, ms_tick;

  always_comb begin
    state_d = state_q;
    cntr_d  = cntr_q;
    presc_d = presc_q;
`ifdef STOPWATCH_OVF_BLINK_EN
    presc_en = (state_q == S_RUN) || (state_q == S_OVF);
`else
    presc_en = (state_q == S_RUN);
`endif
    ms_tick = presc_en && (presc_q == PRESC_MAX);
    if (presc_en) begin
      presc_d = ms_tick ? '0 : presc_q + 1'b1;
    end
    if (clr_ev) begin
      state_d = S_IDLE;
      cntr_d  = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE:  if (ss_ev) state_d = S_RUN;
        S_RUN: begin
          if (ms_tick) begin
            if (cntr_q == 16'h9999) state_d = S_OVF;
            else                    cntr_d  = bcd_inc(cntr_q);
          end
          // A stop request on the saturating tick still lands in OVF.
          if (ss_ev && state_d == S_RUN) state_d = S_PAUSE;
        end
        S_PAUSE: if (ss_ev) state_d = S_RUN;
        default: ;
      endcase
    end
  end

`ifdef STOPWATCH_OVF_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_TICKS + 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] blink_q, blink_d;
  logic          dispen_q, dispen_d;

  // The blink counter only starts on ticks taken while already in OVF.
  always_comb begin
    blink_d  = blink_q;
    dispen_d = dispen_q;
    if (state_d != S_OVF) begin
      blink_d  = '0;
      dispen_d = 1'b1;
    end else if (state_q == S_OVF && ms_tick) begin
      if (blink_q == BLINK_MAX) begin
        blink_d  = '0;
        dispen_d = ~dispen_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q  <= '0;
      dispen_q <= 1'b1;
    end else begin
      blink_q  <= blink_d;
      dispen_q <= dispen_d;
    end
  end

  assign dispen = dispen_q;
`else
  assign dispen = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cntr_q    <= '0;
      presc_q   <= '0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cntr_q    <= cntr_d;
      presc_q   <= presc_d;
      running_q <= (state_d == S_RUN);
      ovf_q     <= (state_d == S_OVF);
    end
  end

  assign cntr    = cntr_q;
  assign running = running_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: an elapsed-time reference model predicts outputs
// every cycle; a monitor on the falling edge compares them against the DUT.
module tb_stopwatch_core;

  localparam int TICK_DIV    = 4;
  localparam int DB_CYCLES   = 3;
  localparam int BLINK_TICKS = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_OVF   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_ss = 1'b0;
  logic        btn_clr = 1'b0;
  logic [15:0] cntr;
  logic        dispen, running, ovf;

  stopwatch_core #(
    .TICK_DIV   (TICK_DIV),
    .DB_CYCLES  (DB_CYCLES),
    .BLINK_TICKS(BLINK_TICKS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_ss (btn_ss),
    .btn_clr(btn_clr),
    .cntr   (cntr),
    .dispen (dispen),
    .running(running),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] cntr;
    logic        running;
    logic        ovf;
    logic        dispen;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: elapsed whole ms plus cycles into the current ms.
  int          mode = M_IDLE;
  int          ms = 0;
  int          frac = 0;
  int          ovf_cycles = 0;
  int          edge_no = 0;
  int          ss_rise = -100;
  int          clr_rise = -100;
  logic        ss_deb = 1'b0;
  logic        clr_deb = 1'b0;
  logic [15:0] ss_hist = '0;
  logic [15:0] clr_hist = '0;
  logic        act_ss, act_clr;
  exp_t        mdl_e;

  // The debounced level flips once the last DB_CYCLES synchronized samples
  // (raw samples 2..DB_CYCLES+1 edges old) all disagree with it.
  function automatic logic flips(input logic [15:0] hist, input logic lvl);
    for (int k = 2; k < DB_CYCLES + 2; k++)
      if (hist[k] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode = M_IDLE; ms = 0; frac = 0; ovf_cycles = 0;
      ss_hist = '0; clr_hist = '0; ss_deb = 1'b0; clr_deb = 1'b0;
      ss_rise = -100; clr_rise = -100;
      exp_q.delete();
    end else begin
      edge_no++;
      act_ss  = (edge_no == ss_rise + 2);
      act_clr = (edge_no == clr_rise + 2);
      if (act_clr) begin
        mode = M_IDLE; ms = 0; frac = 0;
      end else begin
        case (mode)
          M_IDLE:  if (act_ss) mode = M_RUN;
          M_PAUSE: if (act_ss) mode = M_RUN;
          M_RUN: begin
            frac++;
            if (frac == TICK_DIV) begin
              frac = 0;
              if (ms == 9999) begin mode = M_OVF; ovf_cycles = 0; end
              else ms++;
            end
            if (act_ss && mode == M_RUN) mode = M_PAUSE;
          end
          default: ovf_cycles++;
        endcase
      end
      ss_hist  = {ss_hist[14:0], btn_ss};
      clr_hist = {clr_hist[14:0], btn_clr};
      if (flips(ss_hist, ss_deb)) begin
        ss_deb = ~ss_deb;
        if (ss_deb) ss_rise = edge_no;
      end
      if (flips(clr_hist, clr_deb)) begin
        clr_deb = ~clr_deb;
        if (clr_deb) clr_rise = edge_no;
      end
      mdl_e.cntr    = {4'(ms / 1000), 4'((ms / 100) % 10), 4'((ms / 10) % 10), 4'(ms % 10)};
      mdl_e.running = (mode == M_RUN);
      mdl_e.ovf     = (mode == M_OVF);
`ifdef STOPWATCH_OVF_BLINK_EN
      mdl_e.dispen  = (mode != M_OVF) || (((ovf_cycles / (TICK_DIV * BLINK_TICKS)) % 2) == 0);
`else
      mdl_e.dispen  = 1'b1;
`endif
      exp_q.push_back(mdl_e);
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst === 1'b1 && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("cntr",    cntr,              mon_e.cntr);
      chk("running", {15'b0, running},  {15'b0, mon_e.running});
      chk("ovf",     {15'b0, ovf},      {15'b0, mon_e.ovf});
      chk("dispen",  {15'b0, dispen},   {15'b0, mon_e.dispen});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_ss(input int len);
    btn_ss = 1'b1; cyc(len); btn_ss = 1'b0;
  endtask

  task automatic press_clr(input int len);
    btn_clr = 1'b1; cyc(len); btn_clr = 1'b0;
  endtask

  int r;

  initial begin
    rst = 1'b0;
    cyc(3);
    chk("reset_cntr",    cntr,             16'h0000);
    chk("reset_running", {15'b0, running}, 16'h0000);
    chk("reset_ovf",     {15'b0, ovf},     16'h0000);
    chk("reset_dispen",  {15'b0, dispen},  16'h0001);
    rst = 1'b1;

    press_ss(2); cyc(5);              // glitch: no event
    press_ss(10); cyc(40);            // clean start
    press_ss(8); cyc(100);            // pause
    press_ss(8); cyc(30);             // resume from retained remainder

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        press_ss($urandom_range(1, 10));
      end else if (r < 6) begin
        press_clr($urandom_range(1, 8));
      end else if (r < 8) begin
        for (int j = 0; j < 3; j++) begin
          press_ss($urandom_range(1, 2));
          cyc($urandom_range(1, 2));
        end
      end
      cyc($urandom_range(0, 60));
    end

    press_clr(6); cyc(6);
    press_ss(6); cyc(20);
    btn_ss = 1'b1; btn_clr = 1'b1; cyc(6);   // simultaneous: clear wins
    btn_ss = 1'b0; btn_clr = 1'b0; cyc(12);

    press_ss(6); cyc(30);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_rst_cntr",    cntr,             16'h0000);
    chk("async_rst_running", {15'b0, running}, 16'h0000);
    chk("async_rst_ovf",     {15'b0, ovf},     16'h0000);
    chk("async_rst_dispen",  {15'b0, dispen},  16'h0001);
    cyc(3);
    rst = 1'b1;
    cyc(2);

    press_ss(6); cyc(40100);           // run through 9.999 s into OVF
    press_ss(6); cyc(60);              // ignored while saturated
    press_clr(6); cyc(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
